timing_sequencer: RTL and testbench

Sequence-counter control stage for the basic computer. It produces the 3-bit step value that the timing decoder turns into the one-hot T0..T6 timing signals. It also owns run/halt/single-step control. Value 0 means "no timing signal active", so the counter sits at 0 whenever the machine is not executing. Active steps are 1..STEP_LIMIT, which the decoder maps to T0..T(STEP_LIMIT-1).

---
 rtl/timing_sequencer.sv | 124 ++++++++++++
 tb/tb_timing_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timing_sequencer.sv
// ============================================================================
//  Module      : timing_sequencer
//  Description : Sequence-counter control stage. Produces the 3-bit step value
//                for the timing decoder and owns run/halt/single-step control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timing_sequencer #(
    parameter logic [2:0] STEP_LIMIT = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       step_req,
    input  logic       halt,
    input  logic       sc_clr,
    input  logic       stall,
    output logic [2:0] sc_value,
    output logic       running,
    output logic       halted,
    output logic       instr_done,
    output logic       overrun
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_STEP   = 2'd2;
    localparam logic [1:0] c_ST_HALTED = 2'd3;

    localparam logic [2:0] c_SC_IDLE   = 3'd0;
    localparam logic [2:0] c_SC_FIRST  = 3'd1;

    logic [1:0] r_state;
    logic [2:0] r_sc_value;
    logic       r_instr_done;
    logic       r_overrun;

    logic [1:0] w_state_next;
    logic [2:0] w_sc_next;
    logic       w_done_next;
    logic       w_ovr_next;
    logic       w_active;
    logic       w_can_incr;

    assign w_active   = (r_state == c_ST_RUN) || (r_state == c_ST_STEP);
    // Anything at or above the limit takes the wrap path, so a stray value can never run past it.
    assign w_can_incr = (r_sc_value < STEP_LIMIT);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_sc_value   <= c_SC_IDLE;
            r_instr_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_sc_value   <= w_sc_next;
            r_instr_done <= w_done_next;
            r_overrun    <= w_ovr_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_HALTED: begin
                if (start) begin
                    w_state_next = c_ST_RUN;
                end else if (step_req) begin
                    w_state_next = c_ST_STEP;
                end
            end
            c_ST_RUN: begin
                if (halt) begin
                    w_state_next = c_ST_HALTED;
                end
            end
            c_ST_STEP: begin
                if (halt) begin
                    w_state_next = c_ST_HALTED;
                end else if (sc_clr) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Next-output logic; halt outranks sc_clr, which outranks stall
    always_comb begin
        w_sc_next   = c_SC_IDLE;
        w_done_next = 1'b0;
        w_ovr_next  = 1'b0;
        if (w_active) begin
            if (halt) begin
                w_sc_next = c_SC_IDLE;
            end else if (sc_clr) begin
                w_done_next = 1'b1;
                w_sc_next   = (r_state == c_ST_STEP) ? c_SC_IDLE : c_SC_FIRST;
            end else if (stall) begin
                w_sc_next = r_sc_value;
            end else if (w_can_incr) begin
                w_sc_next = r_sc_value + 3'd1;
            end else begin
                w_sc_next  = c_SC_FIRST;
                w_ovr_next = 1'b1;
            end
        end else if (start || step_req) begin
            w_sc_next = c_SC_FIRST;
        end
    end

    assign sc_value   = r_sc_value;
    assign running    = w_active;
    assign halted     = (r_state == c_ST_HALTED);
    assign instr_done = r_instr_done;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_timing_sequencer.sv
// ============================================================================
//  Module      : tb_timing_sequencer
//  Description : Self-checking bench: vector table, corner sequences and
//                randomized run against a behavioural model (limits 7 and 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timing_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start, step_req, halt, sc_clr, stall;
    logic [2:0] sc7, sc4;
    logic       run7, run4, hlt7, hlt4, done7, done4, ovr7, ovr4;

    int n_cmp;
    int n_err;

    timing_sequencer #(.STEP_LIMIT(3'd7)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .start(start), .step_req(step_req),
        .halt(halt), .sc_clr(sc_clr), .stall(stall),
        .sc_value(sc7), .running(run7), .halted(hlt7),
        .instr_done(done7), .overrun(ovr7)
    );

    timing_sequencer #(.STEP_LIMIT(3'd4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .step_req(step_req),
        .halt(halt), .sc_clr(sc_clr), .stall(stall),
        .sc_value(sc4), .running(run4), .halted(hlt4),
        .instr_done(done4), .overrun(ovr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start, step_req, halt, sc_clr, stall;
        logic [2:0] sc;
        logic       run, hlt, done, ovr;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: machine is either executing (one instruction or forever) or not
    bit m_exec[2];
    bit m_single[2];
    bit m_halted[2];
    int m_sc[2];
    bit m_done[2];
    bit m_ovr[2];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_exec[k] = 0; m_single[k] = 0; m_halted[k] = 0;
            m_sc[k] = 0; m_done[k] = 0; m_ovr[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input int lim);
        m_done[k] = 0;
        m_ovr[k]  = 0;
        if (!m_exec[k]) begin
            if (start || step_req) begin
                m_exec[k]   = 1;
                m_single[k] = !start;
                m_halted[k] = 0;
                m_sc[k]     = 1;
            end
        end else if (halt) begin
            m_exec[k] = 0; m_halted[k] = 1; m_sc[k] = 0;
        end else if (sc_clr) begin
            m_done[k] = 1;
            if (m_single[k]) begin
                m_exec[k] = 0; m_sc[k] = 0;
            end else begin
                m_sc[k] = 1;
            end
        end else if (!stall) begin
            if (m_sc[k] < lim) m_sc[k] = m_sc[k] + 1;
            else begin
                m_sc[k] = 1; m_ovr[k] = 1;
            end
        end
    endtask

    task automatic drive(input logic s, input logic sr, input logic h, input logic c, input logic st);
        start = s; step_req = sr; halt = h; sc_clr = c; stall = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic vec_t mk(input logic s, input logic sr, input logic h, input logic c,
                                input logic st, input logic [2:0] sc, input logic r,
                                input logic hl, input logic d, input logic o);
        vec_t v;
        v.start = s; v.step_req = sr; v.halt = h; v.sc_clr = c; v.stall = st;
        v.sc = sc; v.run = r; v.hlt = hl; v.done = d; v.ovr = o;
        return v;
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();

        //            st sr h  c  sl  sc run hlt dn ov
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        for (int i = 2; i <= 7; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 3'(i), 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));

        // Reset state
        tick();
        check("reset_sc", sc7, 0);
        check("reset_running", run7, 0);
        check("reset_halted", hlt7, 0);
        check("reset_done", done7, 0);
        check("reset_ovr", ovr7, 0);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset_sc", sc7, 0);

        // Vector table
        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].step_req, vecs[i].halt, vecs[i].sc_clr, vecs[i].stall);
            tick();
            check($sformatf("vec%0d_sc", i), sc7, vecs[i].sc);
            check($sformatf("vec%0d_running", i), run7, vecs[i].run);
            check($sformatf("vec%0d_halted", i), hlt7, vecs[i].hlt);
            check($sformatf("vec%0d_done", i), done7, vecs[i].done);
            check($sformatf("vec%0d_ovr", i), ovr7, vecs[i].ovr);
        end

        // Wrap at limit 4 with overrun
        do_reset();
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        check("lim4_sc1", sc4, 1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("lim4_sc%0d", i), sc4, i);
            check("lim4_no_ovr", ovr4, 0);
        end
        tick();
        check("lim4_wrap_sc", sc4, 1);
        check("lim4_wrap_ovr", ovr4, 1);
        tick();
        check("lim4_ovr_clear", ovr4, 0);

        // Asynchronous reset mid-instruction at sc_value 6
        do_reset();
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 2; i <= 6; i++) tick();
        check("pre_async_sc", sc7, 6);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sc", sc7, 0);
        check("async_rst_running", run7, 0);
        #1 rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_idle_sc", sc7, 0);
        check("post_rst_idle_running", run7, 0);

        // Randomized run against the model for both limits
        do_reset();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0));
            model_step(0, 7);
            model_step(1, 4);
            tick();
            check("rnd7_sc", sc7, m_sc[0]);
            check("rnd7_running", run7, m_exec[0]);
            check("rnd7_halted", hlt7, m_halted[0]);
            check("rnd7_done", done7, m_done[0]);
            check("rnd7_ovr", ovr7, m_ovr[0]);
            check("rnd4_sc", sc4, m_sc[1]);
            check("rnd4_running", run4, m_exec[1]);
            check("rnd4_halted", hlt4, m_halted[1]);
            check("rnd4_done", done4, m_done[1]);
            check("rnd4_ovr", ovr4, m_ovr[1]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
